// File: rtl/sseg_word_decoder_pkg.sv
// Shared definitions for the seven-segment word decoder: segment codes,
// error encodings and controller states.
package sseg_word_decoder_pkg;

    // Active-low patterns, bit order g,f,e,d,c,b,a.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PATTERN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/sseg_word_decoder_if.sv
// Digit stream in, assembled word and status out, for sseg_word_decoder.
interface sseg_word_decoder_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg_in;
    logic                seg_valid;
    logic                sof;
    logic                word_ack;
    logic [4*DIGITS-1:0] word;
    logic                word_valid;
    logic                err;
    logic [1:0]          err_code;
    logic                overrun;
    logic                busy;

    modport master (
        output seg_in, seg_valid, sof, word_ack,
        input  word, word_valid, err, err_code, overrun, busy
    );

    modport slave (
        input  seg_in, seg_valid, sof, word_ack,
        output word, word_valid, err, err_code, overrun, busy
    );
endinterface

// File: rtl/sseg_word_decoder_decode.sv
// Combinational inverse of the hex-to-seven-segment encoder.
module sseg_decode
    import sseg_word_decoder_pkg::*;
(
    input  logic [6:0] seg_in,
    output logic [3:0] nibble,
    output logic       legal
);

    always_comb begin
        nibble = '0;
        legal  = 1'b1;
        case (seg_in)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/sseg_word_decoder.sv
// Reassembles a stream of seven-segment digits (MSD first) into a word,
// with frame timeout, pattern checking and a valid/ack output handshake.
module sseg_word_decoder
    import sseg_word_decoder_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    sseg_word_decoder_if.slave   bus
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         state_q, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [W-1:0]   word_q, word_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic [1:0]     err_code_q, err_code_d;
    logic           overrun_q, overrun_d;
    logic [3:0]     nib;
    logic           legal;
    logic           take_sof;
    logic [W-1:0]   shift_next;

    sseg_decode u_decode (
        .seg_in (bus.seg_in),
        .nibble (nib),
        .legal  (legal)
    );

    assign shift_next = (shift_q << 4) | W'(nib);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        err_code_d = err_code_q;
        overrun_d  = overrun_q;
        take_sof   = 1'b0;

        unique case (state_q)
            IDLE: take_sof = bus.seg_valid & bus.sof;
            COLLECT: begin
                if (bus.seg_valid && bus.sof) begin
                    take_sof = 1'b1;
                end else if (bus.seg_valid) begin
                    tcnt_d = '0;
                    if (!legal) begin
                        state_d    = ERR;
                        err_code_d = ERR_PATTERN;
                        cnt_d      = '0;
                    end else if (cnt_q == CW'(DIGITS - 1)) begin
                        word_d  = shift_next;
                        shift_d = shift_next;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d    = ERR;
                    err_code_d = ERR_TIMEOUT;
                    tcnt_d     = '0;
                    cnt_d      = '0;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            DONE, ERR: begin
                if (bus.word_ack) begin
                    state_d    = IDLE;
                    err_code_d = ERR_NONE;
                    take_sof   = bus.seg_valid & bus.sof;
                end else if (bus.seg_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.word_ack) overrun_d = 1'b0;

        // A frame start is shared by IDLE, restart-in-COLLECT and ack-with-sof.
        if (take_sof) begin
            tcnt_d = '0;
            if (!legal) begin
                state_d    = ERR;
                err_code_d = ERR_PATTERN;
                cnt_d      = '0;
            end else begin
                shift_d = W'(nib);
                cnt_d   = CW'(1);
                if (DIGITS == 1) begin
                    word_d  = W'(nib);
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    state_d = COLLECT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            err_code_q <= ERR_NONE;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            err_code_q <= err_code_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.word       = word_q;
    assign bus.word_valid = (state_q == DONE);
    assign bus.err        = (state_q == ERR);
    assign bus.err_code   = err_code_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_sseg_word_decoder.sv
// Randomized + directed bench for sseg_word_decoder with a frame-level
// reference model and an event scoreboard.
module tb_sseg_word_decoder;

    localparam int DIGITS  = 4;
    localparam int TIMEOUT = 8;
    localparam int P_IDLE = 0, P_COLLECT = 1, P_DONE = 2, P_ERR = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sseg_word_decoder_if #(.DIGITS(DIGITS)) bus();

    sseg_word_decoder #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [15:0] word;
    } ev_t;

    ev_t         sb[$];
    ev_t         mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [6:0]  tab [16];

    int          phase;
    int          frame[$];
    int          idle;
    bit          m_ovr;
    logic [1:0]  m_code;
    logic [15:0] m_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit lookup(input logic [6:0] s, output logic [3:0] n);
        n = '0;
        for (int i = 0; i < 16; i++) begin
            if (tab[i] == s) begin
                n = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        phase = P_IDLE;
        frame.delete();
        idle = 0;
        m_ovr = 1'b0;
        m_code = 2'b00;
        m_word = '0;
    endfunction

    function automatic void to_err(input logic [1:0] c);
        phase = P_ERR;
        m_code = c;
        frame.delete();
        sb.push_back('{1'b1, c, m_word});
    endfunction

    function automatic void finish_word();
        m_word = '0;
        foreach (frame[i]) m_word = m_word * 16 + 16'(frame[i]);
        phase = P_DONE;
        sb.push_back('{1'b0, 2'b00, m_word});
    endfunction

    function automatic void model_step(input bit v, input bit s, input logic [6:0] seg, input bit a);
        bit         legal;
        logic [3:0] n;
        bit         start;
        start = 1'b0;
        legal = lookup(seg, n);
        case (phase)
            P_IDLE: start = v && s;
            P_COLLECT: begin
                if (v && s) start = 1'b1;
                else if (v) begin
                    if (!legal) to_err(2'b01);
                    else begin
                        frame.push_back(int'(n));
                        idle = 0;
                        if (frame.size() == DIGITS) finish_word();
                    end
                end else begin
                    idle++;
                    if (idle == TIMEOUT) to_err(2'b10);
                end
            end
            default: begin
                if (a) begin
                    phase = P_IDLE;
                    m_code = 2'b00;
                    start = v && s;
                end else if (v) m_ovr = 1'b1;
            end
        endcase
        if (a) m_ovr = 1'b0;
        if (start) begin
            if (!legal) to_err(2'b01);
            else begin
                frame.delete();
                frame.push_back(int'(n));
                idle = 0;
                phase = P_COLLECT;
            end
        end
    endfunction

    task automatic check_levels(input string name);
        logic [21:0] act, exp;
        act = {bus.busy, bus.word_valid, bus.err, bus.err_code, bus.overrun, bus.word};
        exp = {phase == P_COLLECT, phase == P_DONE, phase == P_ERR, m_code, m_ovr, m_word};
        chk(name, 32'(act), 32'(exp));
    endtask

    task automatic cycle(input bit v, input bit s, input logic [6:0] seg, input bit a);
        bus.seg_valid = v;
        bus.sof       = s;
        bus.seg_in    = seg;
        bus.word_ack  = a;
        if (reset) model_step(v, s, seg, a);
        @(posedge clk);
        #1;
        check_levels("levels");
    endtask

    // Scoreboard monitor: a completed word or a fresh error is an event.
    logic prev_wv = 1'b0, prev_err = 1'b0, prev_ack = 1'b0;
    always @(negedge clk) begin
        if ((bus.word_valid && (!prev_wv || prev_ack)) || (bus.err && (!prev_err || prev_ack))) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got wv=%b err=%b word=%h expected no event", bus.word_valid, bus.err, bus.word);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_kind", 32'(bus.err), 32'(mon_e.is_err));
                chk("sb_word", 32'(bus.word), 32'(mon_e.word));
                if (mon_e.is_err) chk("sb_err_code", 32'(bus.err_code), 32'(mon_e.code));
            end
        end
        prev_wv  = bus.word_valid;
        prev_err = bus.err;
        prev_ack = bus.word_ack;
    end

    initial begin
        tab[0]  = 7'b1000000; tab[1]  = 7'b1111001; tab[2]  = 7'b0100100; tab[3]  = 7'b0110000;
        tab[4]  = 7'b0011001; tab[5]  = 7'b0010010; tab[6]  = 7'b0000010; tab[7]  = 7'b1111000;
        tab[8]  = 7'b0000000; tab[9]  = 7'b0010000; tab[10] = 7'b0001000; tab[11] = 7'b0000011;
        tab[12] = 7'b1000110; tab[13] = 7'b0100001; tab[14] = 7'b0000110; tab[15] = 7'b0001110;
        bus.seg_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.seg_in    = '0;
        bus.word_ack  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_levels("reset_state");
        reset = 1'b1;

        // Asynchronous reset in the middle of a frame.
        cycle(1, 1, tab[1], 0);
        cycle(1, 0, tab[2], 0);
        #2 reset = 1'b0;
        model_reset();
        #1 check_levels("async_reset");
        cycle(0, 0, 7'h00, 0);
        cycle(0, 0, 7'h00, 0);
        reset = 1'b1;
        cycle(1, 0, tab[5], 0);

        // 0x1234, held until ack.
        cycle(1, 1, tab[1], 0);
        cycle(1, 0, tab[2], 0);
        cycle(1, 0, tab[3], 0);
        cycle(1, 0, tab[4], 0);
        repeat (5) cycle(0, 0, 7'h00, 0);
        cycle(0, 0, 7'h00, 1);

        // Illegal pattern mid-frame.
        cycle(1, 1, tab[10], 0);
        cycle(1, 0, 7'b1111111, 0);
        cycle(0, 0, 7'h00, 0);
        cycle(0, 0, 7'h00, 1);

        // Inter-digit timeout.
        cycle(1, 1, tab[3], 0);
        cycle(1, 0, tab[7], 0);
        repeat (TIMEOUT) cycle(0, 0, 7'h00, 0);
        cycle(0, 0, 7'h00, 1);

        // Restart discards the partial frame.
        cycle(1, 1, tab[10], 0);
        cycle(1, 0, tab[11], 0);
        cycle(1, 1, tab[12], 0);
        cycle(1, 0, tab[13], 0);
        cycle(1, 0, tab[14], 0);
        cycle(1, 0, tab[15], 0);

        // Overrun, then ack together with a new frame start.
        cycle(1, 0, tab[9], 0);
        cycle(1, 1, tab[8], 1);
        cycle(1, 0, tab[1], 0);
        cycle(1, 0, tab[2], 0);
        cycle(1, 0, tab[3], 0);
        cycle(0, 0, 7'h00, 1);

        for (int i = 0; i < 3000; i++) begin
            logic [6:0] seg;
            if ($urandom_range(0, 9) < 8) seg = tab[$urandom_range(0, 15)];
            else seg = 7'($urandom);
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, seg, $urandom_range(0, 3) == 0);
        end

        repeat (TIMEOUT + 4) cycle(0, 0, 7'h00, 1);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sseg_word_decoder.md
Name: sseg_word_decoder

Overview:
- Receiving end of the hex-to-seven-segment encoding used on the DE1-SoC display path. Accepts a stream of active-low 7-bit segment patterns, one digit per strobe, most-significant digit first.
- Decodes each pattern back to a 4-bit nibble and assembles DIGITS nibbles into a word. Presents the word with a valid/ack handshake.
- Used to read back display contents, for example the CPU out register as shown on HEX3..HEX0, in self-checking board tests.

Parameters:
DIGITS, 4, number of digits per frame; word width W = 4*DIGITS.
TIMEOUT, 1024, maximum clk cycles allowed between accepted digits inside a frame before an error is raised.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
seg_in  input  7  segment pattern, bits 6..0 = segments g,f,e,d,c,b,a; a lit segment is 0.
seg_valid  input  1  strobe: seg_in is presented this cycle.
sof  input  1  qualifies seg_valid: this digit is the first, most-significant digit of a frame.
word_ack  input  1  consumer accepts word or clears an error.
word  output  W  assembled word; first digit lands in bits [W-1:W-4].
word_valid  output  1  word holds a complete frame.
err  output  1  frame aborted.
err_code  output  2  01 = illegal pattern, 10 = timeout, 00 = none.
overrun  output  1  sticky: a digit arrived while in DONE or ERR without word_ack.
busy  output  1  high in COLLECT.

Behaviour:
- Reset (async, reset=0): state IDLE; word=0; word_valid=0; err=0; err_code=00; overrun=0; busy=0; digit count=0; timeout counter=0.
- Legal codes, hex digit: pattern.
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000
  - 4: 0011001, 5: 0010010, 6: 0000010, 7: 1111000
  - 8: 0000000, 9: 0010000, A: 0001000, b: 0000011
  - C: 1000110, d: 0100001, E: 0000110, F: 0001110
  - Any other pattern is illegal.
- IDLE:
  - seg_valid & sof & legal: shift register = nibble; count=1; go to COLLECT. If DIGITS=1, go directly to DONE.
  - seg_valid & !sof: digit ignored, no flag.
  - seg_valid & sof & illegal: go to ERR, err_code=01.
- COLLECT:
  - seg_valid & sof: restart the frame. Previous partial digits are discarded; count=1.
  - seg_valid & !sof & legal: shift left by 4, insert nibble, count+1.
    - When count reaches DIGITS, load word from the shift register and go to DONE.
    - word_valid=1 on the cycle after the clock edge that accepted the last digit (1-cycle latency).
  - Illegal pattern on any accepted digit: go to ERR, err_code=01. word is left unchanged.
  - Timeout counter clears on every accepted digit. When it reaches TIMEOUT with no digit: go to ERR, err_code=10.
- DONE:
  - word_valid held, word stable, until word_ack.
  - word_ack alone: return to IDLE; word_valid=0; word retained.
  - word_ack & seg_valid & sof in the same cycle: the digit is processed as in IDLE (back-to-back frames).
  - seg_valid without word_ack: digit dropped; overrun=1.
- ERR:
  - err=1, err_code held.
  - word_ack: clear err and err_code; go to IDLE. A same-cycle sof digit is processed as in IDLE.
  - seg_valid without word_ack: overrun=1.
- overrun clears only on a word_ack cycle or on reset.
- Reset asserted mid-frame: partial frame discarded immediately; all outputs return to reset values.
- Outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package: the 16 segment code constants, the err_code encodings (ERR_NONE, ERR_PATTERN, ERR_TIMEOUT), and the state encoding (IDLE, COLLECT, DONE, ERR).
- Sub-module sseg_decode: combinational, seg_in[6:0] -> nibble[3:0] plus legal flag.
- The FSM, shift register, digit counter and timeout counter live in the top block.

Test Plan:
1. Reset=0 asserted during COLLECT after 2 digits -> all outputs 0 asynchronously; after release, a digit sent without sof is ignored.
2. Digits 1111001 (sof), 0100100, 0110000, 0011001 on consecutive cycles -> word=16'h1234, word_valid=1 one cycle after the 4th edge, held 5 cycles until word_ack, then 0.
3. Digit 0001000 (sof, A), then 1111111 -> err=1, err_code=01, word unchanged from previous 16'h1234; word_ack -> IDLE, err=0.
4. TIMEOUT=8: two legal digits then 8 idle cycles -> err=1, err_code=10, busy=0.
5. Digits A (sof), b, then C (sof), d, E, F -> word=16'hCDEF; the A and b are discarded.
6. Frame complete, no ack, extra digit arrives -> overrun=1, word stays 16'hCDEF. Then word_ack in the same cycle as a sof digit 8 (0000000) -> overrun=0, state COLLECT, busy=1.
